// File: rtl/safe_softmax_pkg.sv
// Shared types and Q2.13 constants for the safe-softmax row controller.
package safe_softmax_pkg;

    typedef enum logic [1:0] {LOAD, EXP, SUM} sm_state_e;

    localparam int Q_FRAC = 13;
    localparam logic [15:0] Q_ONE = 16'd8192;
    localparam logic signed [15:0] EXP_X_MIN = 16'sh8000;

endpackage

// File: rtl/softmax_row_buf.sv
// Row score buffer: ROW_LEN x D_W registers, one write port and one asynchronous read port.
module softmax_row_buf #(
    parameter int D_W     = 16,
    parameter int ROW_LEN = 64,
    parameter int ADDR_W  = $clog2(ROW_LEN)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [D_W-1:0]    wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [D_W-1:0]    rd_data
);

    logic [D_W-1:0] mem [ROW_LEN];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/safe_softmax_row_ctrl.sv
// Buffers one score row, tracks its max, then streams exp(x - max) through the shared exp unit.
// Optional saturation counter on O_SAT_CNT is enabled by defining SOFTMAX_SAT_CNT_EN.
//
// state | meaning
// LOAD  | accepting scores into the row buffer, tracking the running max
// EXP   | presenting x - max to the exp unit and streaming results out
// SUM   | one-cycle O_SUM_VALID pulse, then back to LOAD with the row cleared
module safe_softmax_row_ctrl
    import safe_softmax_pkg::*;
#(
    parameter int D_W     = 16,
    parameter int ROW_LEN = 64,
    parameter int SUM_W   = D_W + $clog2(ROW_LEN)
) (
    input  logic                         I_CLK,
    input  logic                         I_RST_N,
    input  logic                         I_VALID,
    output logic                         O_READY,
    input  logic signed [D_W-1:0]        I_DATA,
    output logic [D_W-1:0]               O_EXP_X,
    input  logic [D_W-1:0]               I_EXP_Y,
    output logic                         O_VALID,
    input  logic                         I_READY,
    output logic [D_W-1:0]               O_DATA,
    output logic                         O_LAST,
    output logic [SUM_W-1:0]             O_SUM,
    output logic                         O_SUM_VALID
`ifdef SOFTMAX_SAT_CNT_EN
   ,output logic [$clog2(ROW_LEN+1)-1:0] O_SAT_CNT
`endif
);

    localparam int IDX_W = $clog2(ROW_LEN);
    localparam int RD_W  = $clog2(ROW_LEN + 1);

    sm_state_e state, state_nxt;

    logic [IDX_W-1:0]      wr_idx;
    logic [RD_W-1:0]       rd_idx;
    logic signed [D_W-1:0] row_max;
    logic signed [D_W-1:0] buf_rd;
    logic [SUM_W-1:0]      sum_acc;
    logic signed [D_W:0]   diff;
    logic                  beat;
    logic                  adv;
    logic                  rd_done;
    logic                  clamp;

    softmax_row_buf #(
        .D_W     (D_W),
        .ROW_LEN (ROW_LEN),
        .ADDR_W  (IDX_W)
    ) u_row_buf (
        .clk     (I_CLK),
        .wr_en   (beat),
        .wr_addr (wr_idx),
        .wr_data (I_DATA),
        .rd_addr (rd_idx[IDX_W-1:0]),
        .rd_data (buf_rd)
    );

    assign beat    = I_VALID & O_READY;
    assign rd_done = (rd_idx == RD_W'(ROW_LEN));

    // x <= max always, so the only overflow of the widened difference is below -4.0
    assign diff  = {buf_rd[D_W-1], buf_rd} - {row_max[D_W-1], row_max};
    assign clamp = (state == EXP) && !rd_done && (diff[D_W] != diff[D_W-1]);

    always_comb begin
        O_EXP_X = '0;
        if (state == EXP && !rd_done) begin
            O_EXP_X = clamp ? D_W'(EXP_X_MIN) : diff[D_W-1:0];
        end
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        O_READY     = 1'b0;
        O_SUM_VALID = 1'b0;
        adv         = 1'b0;
        case (state)
            LOAD: begin
                O_READY = 1'b1;
                if (I_VALID && wr_idx == IDX_W'(ROW_LEN - 1)) begin
                    state_nxt = EXP;
                end
            end
            EXP: begin
                adv = !O_VALID || I_READY;
                if (O_VALID && I_READY && O_LAST) begin
                    state_nxt = SUM;
                end
            end
            SUM: begin
                O_SUM_VALID = 1'b1;
                state_nxt   = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

`ifdef SOFTMAX_SAT_CNT_EN
    logic [RD_W-1:0] sat_cnt;
    assign O_SAT_CNT = sat_cnt;

    always_ff @(posedge I_CLK) begin
        if (!I_RST_N || state == SUM) begin
            sat_cnt <= '0;
        end else if (state == EXP && adv && !rd_done) begin
            sat_cnt <= sat_cnt + RD_W'(clamp);
        end
    end
`endif

    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            row_max <= '0;
            sum_acc <= '0;
            O_VALID <= 1'b0;
            O_LAST  <= 1'b0;
            O_DATA  <= '0;
            O_SUM   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (beat) begin
                        if (wr_idx == '0 || I_DATA > row_max) begin
                            row_max <= I_DATA;
                        end
                        wr_idx <= (wr_idx == IDX_W'(ROW_LEN - 1)) ? '0 : wr_idx + 1'b1;
                    end
                end
                EXP: begin
                    if (adv) begin
                        if (!rd_done) begin
                            O_DATA  <= I_EXP_Y;
                            O_VALID <= 1'b1;
                            O_LAST  <= (rd_idx == RD_W'(ROW_LEN - 1));
                            sum_acc <= sum_acc + SUM_W'(I_EXP_Y);
                            rd_idx  <= rd_idx + 1'b1;
                        end else begin
                            O_VALID <= 1'b0;
                            O_LAST  <= 1'b0;
                        end
                    end
                    if (state_nxt == SUM) begin
                        O_SUM <= sum_acc;
                    end
                end
                SUM: begin
                    wr_idx  <= '0;
                    rd_idx  <= '0;
                    sum_acc <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_safe_softmax_row_ctrl.sv
// Scoreboard bench for safe_softmax_row_ctrl with a real-valued exp model on O_EXP_X/I_EXP_Y.
module tb_safe_softmax_row_ctrl;

    localparam int D_W     = 16;
    localparam int ROW_LEN = 64;
    localparam int SUM_W   = D_W + $clog2(ROW_LEN);
    localparam int TOL     = 'h40;
    localparam int SUM_TOL = 4096;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [D_W-1:0]         in_data;
    logic [D_W-1:0]         exp_x;
    logic [D_W-1:0]         exp_y;
    logic                   out_valid;
    logic                   out_ready;
    logic [D_W-1:0]         out_data;
    logic                   out_last;
    logic [SUM_W-1:0]       out_sum;
    logic                   sum_valid;
`ifdef SOFTMAX_SAT_CNT_EN
    logic [$clog2(ROW_LEN+1)-1:0] sat_cnt;
`endif

    safe_softmax_row_ctrl #(.D_W(D_W), .ROW_LEN(ROW_LEN)) dut (
        .I_CLK       (clk),
        .I_RST_N     (rst_n),
        .I_VALID     (in_valid),
        .O_READY     (in_ready),
        .I_DATA      (in_data),
        .O_EXP_X     (exp_x),
        .I_EXP_Y     (exp_y),
        .O_VALID     (out_valid),
        .I_READY     (out_ready),
        .O_DATA      (out_data),
        .O_LAST      (out_last),
        .O_SUM       (out_sum),
        .O_SUM_VALID (sum_valid)
`ifdef SOFTMAX_SAT_CNT_EN
       ,.O_SAT_CNT   (sat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for safe_softmax_exp: round(8192 * e^(x/8192))
    function automatic logic [15:0] exp_model(input logic [15:0] x);
        real r;
        r = $exp(real'(int'($signed(x))) / 8192.0) * 8192.0;
        return 16'($rtoi(r + 0.5));
    endfunction

    assign exp_y = exp_model(exp_x);

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          sum_q[$];
    int          sat_q[$];
    logic [15:0] row_v [ROW_LEN];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          sum_seen = 0;
    logic        stall_prev = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_tol(input string name, input int act, input int req, input int tol);
        n_tests++;
        if (act > req + tol || act < req - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, req, tol);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (out_valid) begin
                check("ready_low_in_exp", 32'(in_ready), 32'd0);
            end
            if (stall_prev && out_valid) begin
                check("stall_hold_data", 32'(out_data), 32'(prev_data));
                check("stall_hold_last", 32'(out_last), 32'(prev_last));
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_element", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_tol("exp_data", int'(out_data), int'(e.data), TOL);
                    check("exp_last", 32'(out_last), 32'(e.last));
                end
            end
            if (sum_valid) begin
                sum_seen++;
                check("elements_left_at_sum", 32'(exp_q.size()), 32'd0);
                if (sum_q.size() == 0) begin
                    check("unexpected_sum", 32'd1, 32'd0);
                end else begin
                    check_tol("row_sum", int'(out_sum), sum_q.pop_front(), SUM_TOL);
                end
`ifdef SOFTMAX_SAT_CNT_EN
                if (sat_q.size() != 0) begin
                    check("sat_cnt", 32'(sat_cnt), 32'(sat_q.pop_front()));
                end
`endif
            end
        end
    end

    // Row of def_x everywhere except sp_x at sp_idx, with hand-computed exp results
    task automatic setup_row(input logic [15:0] def_x, input int def_y, input int sp_idx,
                             input logic [15:0] sp_x, input int sp_y, input int sat);
        exp_t e;
        for (int i = 0; i < ROW_LEN; i++) begin
            row_v[i] = (i == sp_idx) ? sp_x : def_x;
            e.data   = 16'((i == sp_idx) ? sp_y : def_y);
            e.last   = (i == ROW_LEN - 1);
            exp_q.push_back(e);
        end
        sum_q.push_back((ROW_LEN - 1) * def_y + sp_y);
        sat_q.push_back(sat);
    endtask

    task automatic drive_row(input int n, input bit hold);
        int t;
        for (int i = 0; i < n; i++) begin
            in_data  = row_v[i];
            in_valid = 1'b1;
            t = 0;
            while (!in_ready && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                check("ready_timeout", 32'd0, 32'd1);
            end
            @(posedge clk);
            #1;
        end
        if (hold) begin
            in_data = 16'h7000;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_sum(input int target);
        int t;
        t = 0;
        while (sum_seen < target && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("sum_timeout", 32'(sum_seen >= target), 32'd1);
    endtask

    initial begin
        int t;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sum_valid", 32'(sum_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_sum", 32'(out_sum), 32'd0);
        check("rst_exp_x", 32'(exp_x), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // all zeros; also measure last-input to O_SUM_VALID latency
        setup_row(16'h0000, 8192, 0, 16'h0000, 8192, 0);
        drive_row(ROW_LEN, 1'b0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!sum_valid && t < 1000);
        check("sum_latency", 32'(t), 32'(ROW_LEN + 2));
        wait_sum(1);

        // element 5 = 1.0, with a 5-cycle stall mid-row
        setup_row(16'h0000, 3013, 5, 16'h2000, 8192, 0);
        drive_row(ROW_LEN, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_sum(2);

        // +max and -min in one row clamps; I_VALID held through EXP/SUM, rows back to back
        setup_row(16'h7FFF, 8192, 1, 16'h8000, 150, 1);
        drive_row(ROW_LEN, 1'b1);
        wait_sum(3);
        setup_row(16'hC000, 3013, ROW_LEN - 1, 16'hE000, 8192, 0);
        drive_row(ROW_LEN, 1'b1);
        wait_sum(4);
        in_valid = 1'b0;

        // difference of exactly -4.0 is not clamped
        setup_row(16'h4000, 8192, 1, 16'hC000, 150, 0);
        drive_row(ROW_LEN, 1'b0);
        wait_sum(5);

        // 30 beats of a partial row, then a one-cycle reset discards it
        for (int i = 0; i < ROW_LEN; i++) row_v[i] = 16'h7000;
        drive_row(30, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        check("midrst_sum", 32'(out_sum), 32'd0);
        check("midrst_sum_valid", 32'(sum_valid), 32'd0);
        setup_row(16'h0000, 8192, 0, 16'h0000, 8192, 0);
        drive_row(ROW_LEN, 1'b0);
        wait_sum(6);
        repeat (100) @(negedge clk);
        check("sum_pulse_count", 32'(sum_seen), 32'd6);
        check("elements_left_end", 32'(exp_q.size()), 32'd0);
        check("sums_left_end", 32'(sum_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
